// File: rtl/flush_redirect_ctrl_pkg.sv
// Shared encodings and defaults for the flush/redirect sequencer.
// Redirect source tags, FSM states, and the event priority picker.
package flush_redirect_ctrl_pkg;

  localparam int MAX_OUTST_DEF = 4;
  localparam int CNT_W_DEF     = 3;

  typedef enum logic [1:0] {
    REDIR_SRC_NONE = 2'd0,
    REDIR_SRC_EXCP = 2'd1,
    REDIR_SRC_ERTN = 2'd2,
    REDIR_SRC_BR   = 2'd3
  } redir_src_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } redir_state_t;

  typedef struct packed {
    redir_src_t  src;
    logic [31:0] pc;
  } redir_t;

  // Exception beats ertn beats branch; the loser is dropped entirely.
  function automatic redir_t pick_event(input logic        excp,
                                        input logic        ertn,
                                        input logic        br,
                                        input logic [31:0] eentry,
                                        input logic [31:0] era,
                                        input logic [31:0] br_target);
    redir_t r;
    r.src = REDIR_SRC_NONE;
    r.pc  = '0;
    if (excp) begin
      r.src = REDIR_SRC_EXCP;
      r.pc  = eentry;
    end else if (ertn) begin
      r.src = REDIR_SRC_ERTN;
      r.pc  = era;
    end else if (br) begin
      r.src = REDIR_SRC_BR;
      r.pc  = br_target;
    end
    return r;
  endfunction

endpackage

// File: rtl/flush_redirect_ctrl_outst_tracker.sv
// Counts inst-bus requests in flight and how many of them belong to cancelled fetches.
// Latency: discard_resp is combinational on resp_fire; counts update next edge.
// Backpressure: req_block stalls new requests once MAX_OUTST are in flight.
module flush_redirect_ctrl_outst_tracker
  import flush_redirect_ctrl_pkg::*;
#(
  parameter int MAX_OUTST = MAX_OUTST_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic req_fire,
  input  logic resp_fire,
  input  logic flush,
  output logic discard_resp,
  output logic req_block
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0] outst_cnt, outst_nxt;
  logic [CNT_W-1:0] disc_cnt, disc_nxt;

  assign req_block    = (outst_cnt == MAX_CNT);
  assign discard_resp = resp_fire & (disc_cnt != '0);

  always_comb begin
    outst_nxt = outst_cnt;
    if (req_fire && !resp_fire && outst_cnt != MAX_CNT)
      outst_nxt = outst_cnt + 1'b1;
    else if (resp_fire && !req_fire && outst_cnt != '0)
      outst_nxt = outst_cnt - 1'b1;
  end

  // A flush kills everything still in flight after this cycle, including a
  // request accepted this very cycle; it replaces any older dead count.
  always_comb begin
    disc_nxt = disc_cnt;
    if (flush)
      disc_nxt = outst_nxt;
    else if (discard_resp)
      disc_nxt = disc_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outst_cnt <= '0;
      disc_cnt  <= '0;
    end else begin
      outst_cnt <= outst_nxt;
      disc_cnt  <= disc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && req_fire)
      assert (!req_block) else $error("if_req_fire while req_block");
  end

endmodule

// File: rtl/flush_redirect_ctrl.sv
// Flush/redirect sequencer between WB, EX and IF; holds one redirect PC until IF takes it.
// Latency: flushes same cycle; redirect_valid one cycle after the event.
// Backpressure: redirect held until redirect_ready; req_block when inst bus is full.
module flush_redirect_ctrl
  import flush_redirect_ctrl_pkg::*;
#(
  parameter int MAX_OUTST = MAX_OUTST_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  input  logic [31:0] eentry,
  input  logic [31:0] era,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        if_req_fire,
  input  logic        if_resp_fire,
  input  logic        redirect_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_wb_evt,
  output logic        flush_br,
  output logic        discard_resp,
  output logic        req_block
);

  redir_state_t state_q, state_nxt;
  redir_t       cur_q, cur_nxt;
  redir_t       evt;
  logic         evt_vld;
  logic         wb_evt;
  logic         load;

  assign wb_evt       = excp_flush | ertn_flush;
  assign flush_wb_evt = wb_evt;
  assign flush_br     = br_taken & ~wb_evt;

  assign evt     = pick_event(excp_flush, ertn_flush, br_taken, eentry, era, br_target);
  assign evt_vld = (evt.src != REDIR_SRC_NONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cur_q   <= '{src: REDIR_SRC_NONE, pc: 32'h0};
    end else begin
      state_q <= state_nxt;
      cur_q   <= cur_nxt;
    end
  end

  // While a redirect is still pending, a branch may only replace a branch:
  // a WB redirect already squashed the path that branch came from.
  always_comb begin
    state_nxt = state_q;
    cur_nxt   = cur_q;
    load      = 1'b0;
    case (state_q)
      ST_IDLE:  load = evt_vld;
      ST_REDIR: load = redirect_ready ? evt_vld
                                      : (wb_evt | (br_taken & (cur_q.src == REDIR_SRC_BR)));
      default:  load = 1'b0;
    endcase
    if (load) begin
      state_nxt = ST_REDIR;
      cur_nxt   = evt;
    end else if (state_q == ST_REDIR && redirect_ready) begin
      state_nxt   = ST_IDLE;
      cur_nxt.src = REDIR_SRC_NONE;
    end
  end

  always_comb begin
    redirect_valid = (state_q == ST_REDIR);
    redirect_pc    = cur_q.pc;
  end

  flush_redirect_ctrl_outst_tracker #(
    .MAX_OUTST (MAX_OUTST),
    .CNT_W     (CNT_W)
  ) u_outst_tracker (
    .clk          (clk),
    .reset        (reset),
    .req_fire     (if_req_fire),
    .resp_fire    (if_resp_fire),
    .flush        (wb_evt | br_taken),
    .discard_resp (discard_resp),
    .req_block    (req_block)
  );

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
// Directed bench for flush_redirect_ctrl with scoreboard queues for redirect PCs and discard flags.
module tb_flush_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        excp_flush, ertn_flush, br_taken;
  logic [31:0] eentry, era, br_target;
  logic        if_req_fire, if_resp_fire, redirect_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_wb_evt, flush_br, discard_resp, req_block;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_pc_q[$];
  logic        exp_disc_q[$];

  always #5 clk = ~clk;

  flush_redirect_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .excp_flush     (excp_flush),
    .ertn_flush     (ertn_flush),
    .eentry         (eentry),
    .era            (era),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .if_req_fire    (if_req_fire),
    .if_resp_fire   (if_resp_fire),
    .redirect_ready (redirect_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_wb_evt   (flush_wb_evt),
    .flush_br       (flush_br),
    .discard_resp   (discard_resp),
    .req_block      (req_block)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic empty_q(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s observed=no-entry expected=scoreboard-entry", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    excp_flush     = 1'b0;
    ertn_flush     = 1'b0;
    br_taken       = 1'b0;
    if_req_fire    = 1'b0;
    if_resp_fire   = 1'b0;
    redirect_ready = 1'b0;
  endtask

  task automatic accept(input string tag);
    redirect_ready = 1'b1;
    #1;
    chk({tag, "_vld"}, redirect_valid, 1);
    if (exp_pc_q.size() == 0) empty_q({tag, "_pc"});
    else chk({tag, "_pc"}, redirect_pc, exp_pc_q.pop_front());
    tick();
    redirect_ready = 1'b0;
  endtask

  task automatic resp(input string tag);
    if_resp_fire = 1'b1;
    #1;
    if (exp_disc_q.size() == 0) empty_q(tag);
    else chk(tag, discard_resp, exp_disc_q.pop_front());
    tick();
    if_resp_fire = 1'b0;
  endtask

  task automatic req_n(input int n);
    for (int i = 0; i < n; i++) begin
      if_req_fire = 1'b1;
      tick();
    end
    if_req_fire = 1'b0;
  endtask

  task automatic branch(input logic [31:0] tgt);
    br_taken  = 1'b1;
    br_target = tgt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    reset = 1'b1;
    clr();
    eentry = '0; era = '0; br_target = '0;
    tick();
    tick();
    chk("rst_vld", redirect_valid, 0);
    chk("rst_pc", redirect_pc, 0);
    chk("rst_wb", flush_wb_evt, 0);
    chk("rst_br", flush_br, 0);
    chk("rst_disc", discard_resp, 0);
    chk("rst_blk", req_block, 0);
    reset = 1'b0;
    tick();

    // exception: same-cycle flush, redirect next cycle
    excp_flush = 1'b1; eentry = 32'h1c008000;
    #1;
    chk("excp_wb", flush_wb_evt, 1);
    chk("excp_br", flush_br, 0);
    chk("excp_vld_early", redirect_valid, 0);
    exp_pc_q.push_back(32'h1c008000);
    tick(); clr();
    chk("excp_vld", redirect_valid, 1);
    chk("excp_pc", redirect_pc, 32'h1c008000);
    accept("excp_acc");
    chk("excp_idle", redirect_valid, 0);

    // exception beats branch in the same cycle
    excp_flush = 1'b1; branch(32'h1c000100);
    #1;
    chk("pri_br", flush_br, 0);
    chk("pri_wb", flush_wb_evt, 1);
    exp_pc_q.push_back(32'h1c008000);
    tick(); clr();
    accept("pri_acc");

    // held branch redirect, then ertn overwrites it, later branch ignored
    branch(32'h1c000100);
    #1;
    chk("br_flush", flush_br, 1);
    tick(); clr();
    for (int i = 0; i < 3; i++) begin
      chk("hold_vld", redirect_valid, 1);
      chk("hold_pc", redirect_pc, 32'h1c000100);
      tick();
    end
    ertn_flush = 1'b1; era = 32'h1c0000f0;
    #1;
    chk("ertn_wb", flush_wb_evt, 1);
    exp_pc_q.push_back(32'h1c0000f0);
    tick(); clr();
    branch(32'h1c000200);
    #1;
    chk("br_under_wb", flush_br, 1);
    tick(); clr();
    accept("ertn_acc");

    // branch replaces branch; new event with ready wins over old
    branch(32'h1c000300);
    tick(); clr();
    branch(32'h1c000350);
    tick(); clr();
    chk("br_ovr_pc", redirect_pc, 32'h1c000350);
    redirect_ready = 1'b1; branch(32'h1c000400);
    #1;
    chk("acc_old_pc", redirect_pc, 32'h1c000350);
    exp_pc_q.push_back(32'h1c000400);
    tick(); clr();
    accept("new_acc");

    // 3 in flight then branch: three dead responses, fourth live
    req_n(3);
    chk("blk3", req_block, 0);
    branch(32'h1c000500);
    #1;
    chk("t4_br", flush_br, 1);
    exp_pc_q.push_back(32'h1c000500);
    tick(); clr();
    accept("t4_acc");
    req_n(1);
    chk("blk4", req_block, 1);
    exp_disc_q.push_back(1'b1); exp_disc_q.push_back(1'b1);
    exp_disc_q.push_back(1'b1); exp_disc_q.push_back(1'b0);
    resp("t4_d0");
    chk("t4_unblk", req_block, 0);
    resp("t4_d1");
    resp("t4_d2");
    resp("t4_d3");

    // fill to limit without flush: all responses live
    req_n(3);
    chk("t5_blk3", req_block, 0);
    req_n(1);
    chk("t5_blk4", req_block, 1);
    exp_disc_q.push_back(1'b0);
    resp("t5_r0");
    chk("t5_unblk", req_block, 0);
    for (int i = 0; i < 3; i++) begin
      exp_disc_q.push_back(1'b0);
      resp("t5_rn");
    end

    // flush with request and live response in the same cycle
    req_n(2);
    exp_disc_q.push_back(1'b0);
    branch(32'h1c000600); if_req_fire = 1'b1; if_resp_fire = 1'b1;
    #1;
    chk("t6_live", discard_resp, exp_disc_q.pop_front());
    exp_pc_q.push_back(32'h1c000600);
    tick(); clr();
    accept("t6_acc");
    exp_disc_q.push_back(1'b1); exp_disc_q.push_back(1'b1);
    resp("t6_d0");
    resp("t6_d1");

    // flush while dead responses remain: count recomputed from in-flight
    req_n(3);
    branch(32'h1c000700);
    exp_pc_q.push_back(32'h1c000700);
    tick(); clr();
    accept("t7_acc");
    exp_disc_q.push_back(1'b1);
    resp("t7_d0");
    req_n(1);
    excp_flush = 1'b1; eentry = 32'h1c008800;
    exp_pc_q.push_back(32'h1c008800);
    tick(); clr();
    accept("t7_acc2");
    exp_disc_q.push_back(1'b1); exp_disc_q.push_back(1'b1); exp_disc_q.push_back(1'b1);
    resp("t7_d1");
    resp("t7_d2");
    resp("t7_d3");

    // reset in REDIR with dead responses pending
    req_n(2);
    branch(32'h1c000900);
    tick(); clr();
    chk("t8_pre_vld", redirect_valid, 1);
    reset = 1'b1;
    tick();
    chk("t8_vld", redirect_valid, 0);
    chk("t8_pc", redirect_pc, 0);
    reset = 1'b0;
    req_n(1);
    exp_disc_q.push_back(1'b0);
    resp("t8_live");
    chk("t8_blk", req_block, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
